// File: rtl/async_fifo.sv
// Single-clock FIFO for DATA_WIDTH-bit words with registered read data and
// count-decoded full/empty flags. The name is historical; there is no CDC here.
module async_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] buf_in,
  output logic [DATA_WIDTH-1:0] buf_out,
  output logic                  buf_empty,
  output logic                  buf_full,
  output logic [ADDR_WIDTH:0]   buf_count
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_out;

  logic w_wr_acc;
  logic w_rd_acc;

  // Flags come straight from the registered count, so no input reaches them
  // combinationally; a full FIFO can therefore still accept a same-cycle read.
  assign buf_empty = (r_count == '0);
  assign buf_full  = (r_count == FULL_COUNT);
  assign buf_count = r_count;
  assign buf_out   = r_out;

  assign w_wr_acc = wr_en && !buf_full;
  assign w_rd_acc = rd_en && !buf_empty;

  // NOTE: state registers use non-blocking assignments so every process reads
  // the pre-edge value, independent of simulator evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_out    <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_rd_acc) begin
        r_out    <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + (ADDR_WIDTH + 1)'(1);
        2'b01:   r_count <= r_count - (ADDR_WIDTH + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; after reset the pointers make old
  // contents unreachable, and leaving it out lets the array map to plain RAM.
  always_ff @(posedge clk) begin
    if (rst && w_wr_acc) begin
      r_mem[r_wr_ptr] <= buf_in;
    end
  end

endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo: a queue-based reference model predicts read
// data and status; a separate monitor compares buf_out on every accepted read.
module tb_async_fifo;

  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 16;
  localparam int ADDR_WIDTH = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] buf_in;
  logic [DATA_WIDTH-1:0] buf_out;
  logic                  buf_empty;
  logic                  buf_full;
  logic [ADDR_WIDTH:0]   buf_count;

  async_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .buf_in   (buf_in),
    .buf_out  (buf_out),
    .buf_empty(buf_empty),
    .buf_full (buf_full),
    .buf_count(buf_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_WIDTH-1:0] model_q[$];   // words the FIFO should hold, oldest first
  logic [DATA_WIDTH-1:0] exp_q[$];     // read data the monitor should see next
  logic [DATA_WIDTH-1:0] model_out;    // value buf_out should hold

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, then update the model and check
  // status 1 time unit after the rising edge.
  task automatic cycle(input bit wr, input bit rd, input logic [DATA_WIDTH-1:0] data,
                       input bit rst_n = 1'b1);
    bit rd_ok;
    bit wr_ok;
    @(negedge clk);
    rst    = rst_n;
    wr_en  = wr;
    rd_en  = rd;
    buf_in = data;
    @(posedge clk);
    #1;
    rd_ok = 1'b0;
    if (!rst_n) begin
      model_q.delete();
      model_out = '0;
    end else begin
      rd_ok = rd && (model_q.size() != 0);
      wr_ok = wr && (model_q.size() != DEPTH);
      if (rd_ok) begin
        model_out = model_q.pop_front();
        exp_q.push_back(model_out);
      end
      if (wr_ok) model_q.push_back(data);
    end
    check("buf_count", 32'(buf_count), 32'(model_q.size()));
    check("buf_empty", 32'(buf_empty), 32'(model_q.size() == 0));
    check("buf_full",  32'(buf_full),  32'(model_q.size() == DEPTH));
    if (!rd_ok) check("buf_out_hold", 32'(buf_out), 32'(model_out));
  endtask

  // Monitor: whenever the DUT accepts a read, the next value on buf_out must be
  // the oldest outstanding expectation.
  always @(posedge clk) begin
    if (rst === 1'b1 && rd_en === 1'b1 && buf_empty === 1'b0) begin
      #2;
      if (exp_q.size() == 0) begin
        check("unexpected_read", 32'(buf_out), 32'hFFFF_FFFF);
      end else begin
        check("read_data", 32'(buf_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; buf_in = '0;
    model_out = '0;

    // Reset held for two cycles.
    repeat (2) cycle(1'b0, 1'b0, 8'h00, 1'b0);

    // Basic ordering.
    cycle(1'b1, 1'b0, 8'hA1);
    cycle(1'b1, 1'b0, 8'hB2);
    cycle(1'b1, 1'b0, 8'hC3);
    cycle(1'b1, 1'b0, 8'hD4);
    repeat (4) cycle(1'b0, 1'b1, 8'h00);

    // Underflow: buf_out must hold 0xD4.
    repeat (3) cycle(1'b0, 1'b1, 8'h00);
    check("underflow_hold", 32'(buf_out), 32'h0000_00D4);

    // Fill, overflow attempt, drain.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'(i));
    cycle(1'b1, 1'b0, 8'hFF);
    repeat (DEPTH) cycle(1'b0, 1'b1, 8'h00);

    // Simultaneous access with pointer wrap.
    cycle(1'b1, 1'b0, 8'hE5);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 8'(8'h10 + i));
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b1, 1'b0, 8'(8'h80 + i));
    cycle(1'b1, 1'b1, 8'h77);
    repeat (DEPTH - 1) cycle(1'b0, 1'b1, 8'h00);

    // Reset during operation.
    cycle(1'b1, 1'b0, 8'h31);
    cycle(1'b1, 1'b0, 8'h32);
    cycle(1'b1, 1'b0, 8'h33);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h00);

    // Randomized traffic in phases biased toward filling, draining and mixing.
    for (int phase = 0; phase < 6; phase++) begin
      int wr_pct;
      int rd_pct;
      wr_pct = (phase % 3 == 0) ? 85 : (phase % 3 == 1) ? 20 : 55;
      rd_pct = (phase % 3 == 0) ? 20 : (phase % 3 == 1) ? 85 : 55;
      for (int i = 0; i < 80; i++) begin
        cycle(32'($urandom_range(0, 99)) < wr_pct,
              32'($urandom_range(0, 99)) < rd_pct,
              8'($urandom),
              $urandom_range(0, 149) != 0);
      end
    end

    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
